// File: rtl/memory_region_controller.sv
// Single-master bus decoder into REGION_COUNT address windows.
// One transaction in flight; per-region wait states and write protection.
module memory_region_controller #(
    parameter int WIDTH_DATA   = 16,
    parameter int WIDTH_ADDR   = 20,
    parameter int REGION_COUNT = 4,
    parameter logic [REGION_COUNT*WIDTH_ADDR-1:0] REGION_BASE =
        {20'hF_0000, 20'hC_0000, 20'hA_0000, 20'h0_0000},
    parameter logic [REGION_COUNT*WIDTH_ADDR-1:0] REGION_END =
        {20'hF_FFFF, 20'hC_7FFF, 20'hB_FFFF, 20'h9_FFFF},
    parameter logic [REGION_COUNT-1:0] REGION_READONLY = 4'b1100,
    parameter logic [REGION_COUNT*4-1:0] REGION_WAIT =
        {4'd2, 4'd2, 4'd1, 4'd0}
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [WIDTH_ADDR-1:0]            req_address,
    input  logic [WIDTH_DATA-1:0]            req_write_data,
    output logic                             resp_valid,
    output logic                             resp_error,
    output logic [WIDTH_DATA-1:0]            resp_data,
    output logic [REGION_COUNT-1:0]          region_enable,
    output logic                             region_write,
    output logic [WIDTH_ADDR-1:0]            region_address,
    output logic [WIDTH_DATA-1:0]            region_write_data,
    input  logic [REGION_COUNT*WIDTH_DATA-1:0] region_read_data
);

    localparam int IDX_W = (REGION_COUNT > 1) ? $clog2(REGION_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA,
        RESPOND
    } state_t;

    state_t state;
    state_t next_state;

    logic                    accept;
    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic [WIDTH_ADDR-1:0]   hit_base;
    logic                    hit_ro;
    logic [3:0]              hit_wait;

    logic                    lat_write;
    logic [IDX_W-1:0]        lat_idx;
    logic [3:0]              lat_wait;
    logic [3:0]              wait_cnt;
    logic [WIDTH_DATA-1:0]   rd_sel;

    logic                    ready_d;
    logic                    valid_d;
    logic                    error_d;
    logic [WIDTH_DATA-1:0]   data_d;
    logic [REGION_COUNT-1:0] en_d;
    logic                    wr_d;
    logic [WIDTH_ADDR-1:0]   addr_d;
    logic [WIDTH_DATA-1:0]   wdata_d;

    assign accept = req_valid && req_ready && (state == IDLE);

    // Descending scan so the lowest matching index is the last writer
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        hit_ro   = 1'b0;
        hit_wait = '0;
        for (int i = REGION_COUNT - 1; i >= 0; i--) begin
            if (req_address >= REGION_BASE[i*WIDTH_ADDR +: WIDTH_ADDR] &&
                req_address <= REGION_END[i*WIDTH_ADDR +: WIDTH_ADDR]) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_base = REGION_BASE[i*WIDTH_ADDR +: WIDTH_ADDR];
                hit_ro   = REGION_READONLY[i];
                hit_wait = REGION_WAIT[i*4 +: 4];
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (lat_idx == IDX_W'(i)) begin
                rd_sel = region_read_data[i*WIDTH_DATA +: WIDTH_DATA];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            lat_write         <= 1'b0;
            lat_idx           <= '0;
            lat_wait          <= '0;
            wait_cnt          <= '0;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_error        <= 1'b0;
            resp_data         <= '0;
            region_enable     <= '0;
            region_write      <= 1'b0;
            region_address    <= '0;
            region_write_data <= '0;
        end else begin
            state             <= next_state;
            req_ready         <= ready_d;
            resp_valid        <= valid_d;
            resp_error        <= error_d;
            resp_data         <= data_d;
            region_enable     <= en_d;
            region_write      <= wr_d;
            region_address    <= addr_d;
            region_write_data <= wdata_d;
            if (accept) begin
                lat_write <= req_write;
                lat_idx   <= hit_idx;
                lat_wait  <= hit_wait;
            end
            if (state == ACCESS) begin
                wait_cnt <= lat_wait;
            end else if (state == DATA && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!hit || (req_write && hit_ro)) begin
                        next_state = RESPOND;
                    end else begin
                        next_state = ACCESS;
                    end
                end
            end
            ACCESS:  next_state = DATA;
            DATA: begin
                if (wait_cnt == 4'd0) begin
                    next_state = RESPOND;
                end
            end
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the next cycle, registered above
    always_comb begin
        ready_d = (next_state == IDLE);
        valid_d = (next_state == RESPOND);
        error_d = 1'b0;
        data_d  = '0;
        en_d    = '0;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        if (accept) begin
            if (next_state == RESPOND) begin
                error_d = 1'b1;
            end else begin
                en_d[hit_idx] = 1'b1;
                wr_d          = req_write;
                addr_d        = req_address - hit_base;
                wdata_d       = req_write_data;
            end
        end
        if (state == DATA && wait_cnt == 4'd0 && !lat_write) begin
            data_d = rd_sel;
        end
    end

endmodule

// File: tb/tb_memory_region_controller.sv
// Directed bench for memory_region_controller with a
// small synchronous slave model behind each region.
module tb_memory_region_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [19:0] req_address;
    logic [15:0] req_write_data;
    logic        resp_valid;
    logic        resp_error;
    logic [15:0] resp_data;
    logic [3:0]  region_enable;
    logic        region_write;
    logic [19:0] region_address;
    logic [15:0] region_write_data;
    logic [63:0] region_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_region_controller dut (
        .clock             (clk),
        .reset             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_write_data    (req_write_data),
        .resp_valid        (resp_valid),
        .resp_error        (resp_error),
        .resp_data         (resp_data),
        .region_enable     (region_enable),
        .region_write      (region_write),
        .region_address    (region_address),
        .region_write_data (region_write_data),
        .region_read_data  (region_read_data)
    );

    // Slave arrays indexed by offset[4:0], one-cycle read latency
    logic [15:0] mem [4][32];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 32; j++)
                    mem[i][j] <= 16'h0000;
            mem[0][16]       <= 16'h1234;
            mem[3][0]        <= 16'hCAFE;
            region_read_data <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (region_enable[i]) begin
                    if (region_write)
                        mem[i][region_address[4:0]] <= region_write_data;
                    else
                        region_read_data[i*16 +: 16] <=
                            mem[i][region_address[4:0]];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle t0+1 (just after the handshake edge)
    task automatic issue(input logic w, input logic [19:0] a,
                         input logic [15:0] d);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: got %b required 1", req_ready);
        end
        req_valid      = 1'b1;
        req_write      = w;
        req_address    = a;
        req_write_data = d;
        step();
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_address    = '0;
        req_write_data = '0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_address = 20'h00010;
        step();
        step();
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++;
            $display("FAIL rst_ready: got %b required 0", req_ready); end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin n_fail++;
            $display("FAIL rst_resp: got v=%b e=%b required 0 0",
                     resp_valid, resp_error); end
        n_checks++;
        if (resp_data !== 16'h0) begin n_fail++;
            $display("FAIL rst_data: got %h required 0000", resp_data); end
        n_checks++;
        if (region_enable !== 4'b0 || region_write !== 1'b0) begin n_fail++;
            $display("FAIL rst_strobe: got en=%b w=%b required 0 0",
                     region_enable, region_write); end
        n_checks++;
        if (region_address !== 20'h0 || region_write_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_addr: got a=%h d=%h required 0 0",
                     region_address, region_write_data); end
        req_valid   = 1'b0;
        req_address = '0;
        rst_n       = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_release_ready: got %b required 1",
                     req_ready); end
        n_checks++;
        if (region_enable !== 4'b0) begin n_fail++;
            $display("FAIL rst_no_accept: got %b required 0000",
                     region_enable); end
    endtask

    task automatic test_ram_read();
        issue(1'b0, 20'h00010, 16'h0);
        n_checks++;
        if (region_enable !== 4'b0001) begin n_fail++;
            $display("FAIL ram_en: got %b required 0001", region_enable); end
        n_checks++;
        if (region_address !== 20'h00010 || region_write !== 1'b0) begin
            n_fail++;
            $display("FAIL ram_addr: got a=%h w=%b required 00010 0",
                     region_address, region_write); end
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL ram_access: got rdy=%b v=%b required 0 0",
                     req_ready, resp_valid); end
        step();
        n_checks++;
        if (region_enable !== 4'b0 || resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL ram_data: got en=%b v=%b required 0 0",
                     region_enable, resp_valid); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 ||
            resp_data !== 16'h1234) begin n_fail++;
            $display("FAIL ram_resp: got v=%b e=%b d=%h required 1 0 1234",
                     resp_valid, resp_error, resp_data); end
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
            $display("FAIL ram_idle: got v=%b rdy=%b required 0 1",
                     resp_valid, req_ready); end
    endtask

    task automatic test_video_write_read();
        issue(1'b1, 20'hA0004, 16'hBEEF);
        n_checks++;
        if (region_enable !== 4'b0010 || region_write !== 1'b1) begin
            n_fail++;
            $display("FAIL vid_wr_en: got en=%b w=%b required 0010 1",
                     region_enable, region_write); end
        n_checks++;
        if (region_address !== 20'h00004 ||
            region_write_data !== 16'hBEEF) begin n_fail++;
            $display("FAIL vid_wr_addr: got a=%h d=%h required 00004 beef",
                     region_address, region_write_data); end
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL vid_wr_early: got %b required 0", resp_valid); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 ||
            resp_data !== 16'h0) begin n_fail++;
            $display("FAIL vid_wr_resp: got v=%b e=%b d=%h required 1 0 0",
                     resp_valid, resp_error, resp_data); end
        step();
        issue(1'b0, 20'hA0004, 16'h0);
        n_checks++;
        if (region_enable !== 4'b0010 || region_address !== 20'h00004 ||
            region_write !== 1'b0) begin n_fail++;
            $display("FAIL vid_rd_en: got en=%b a=%h w=%b required 0010 4 0",
                     region_enable, region_address, region_write); end
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL vid_rd_early: got %b required 0", resp_valid); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF) begin n_fail++;
            $display("FAIL vid_rd_resp: got v=%b d=%h required 1 beef",
                     resp_valid, resp_data); end
    endtask

    task automatic test_protected();
        issue(1'b1, 20'hF0000, 16'h1111);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 ||
            resp_data !== 16'h0) begin n_fail++;
            $display("FAIL ro_wr_resp: got v=%b e=%b d=%h required 1 1 0",
                     resp_valid, resp_error, resp_data); end
        n_checks++;
        if (region_enable !== 4'b0) begin n_fail++;
            $display("FAIL ro_wr_strobe: got %b required 0000",
                     region_enable); end
        step();
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL ro_wr_next: got rdy=%b v=%b required 1 0",
                     req_ready, resp_valid); end
        issue(1'b0, 20'hF0000, 16'h0);
        n_checks++;
        if (region_enable !== 4'b1000 || region_address !== 20'h0) begin
            n_fail++;
            $display("FAIL ro_rd_en: got en=%b a=%h required 1000 0",
                     region_enable, region_address); end
        step();
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL ro_rd_early: got %b required 0", resp_valid); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 ||
            resp_data !== 16'hCAFE) begin n_fail++;
            $display("FAIL ro_rd_resp: got v=%b e=%b d=%h required 1 0 cafe",
                     resp_valid, resp_error, resp_data); end
    endtask

    task automatic test_unmapped();
        issue(1'b0, 20'hD0000, 16'h0);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 ||
            resp_data !== 16'h0) begin n_fail++;
            $display("FAIL unmap_resp: got v=%b e=%b d=%h required 1 1 0",
                     resp_valid, resp_error, resp_data); end
        n_checks++;
        if (region_enable !== 4'b0) begin n_fail++;
            $display("FAIL unmap_strobe: got %b required 0000",
                     region_enable); end
        step();
        n_checks++;
        if (region_enable !== 4'b0 || resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL unmap_after: got en=%b v=%b required 0 0",
                     region_enable, resp_valid); end
    endtask

    task automatic test_boundaries();
        issue(1'b0, 20'h9FFFF, 16'h0);
        n_checks++;
        if (region_enable !== 4'b0001 || region_address !== 20'h9FFFF) begin
            n_fail++;
            $display("FAIL bnd_9ffff: got en=%b a=%h required 0001 9ffff",
                     region_enable, region_address); end
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin n_fail++;
            $display("FAIL bnd_9ffff_resp: got v=%b e=%b required 1 0",
                     resp_valid, resp_error); end
        issue(1'b0, 20'hA0000, 16'h0);
        n_checks++;
        if (region_enable !== 4'b0010 || region_address !== 20'h0) begin
            n_fail++;
            $display("FAIL bnd_a0000: got en=%b a=%h required 0010 0",
                     region_enable, region_address); end
        step();
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b1) begin n_fail++;
            $display("FAIL bnd_a0000_resp: got %b required 1", resp_valid); end
        issue(1'b0, 20'hC7FFF, 16'h0);
        n_checks++;
        if (region_enable !== 4'b0100 || region_address !== 20'h07FFF) begin
            n_fail++;
            $display("FAIL bnd_c7fff: got en=%b a=%h required 0100 07fff",
                     region_enable, region_address); end
        step();
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL bnd_c7fff_early: got %b required 0",
                     resp_valid); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin n_fail++;
            $display("FAIL bnd_c7fff_resp: got v=%b e=%b required 1 0",
                     resp_valid, resp_error); end
        issue(1'b0, 20'hC8000, 16'h0);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 ||
            region_enable !== 4'b0) begin n_fail++;
            $display("FAIL bnd_c8000: got v=%b e=%b en=%b required 1 1 0000",
                     resp_valid, resp_error, region_enable); end
    endtask

    task automatic test_reset_in_data();
        issue(1'b0, 20'hF0010, 16'h0);
        n_checks++;
        if (region_enable !== 4'b1000) begin n_fail++;
            $display("FAIL rdat_en: got %b required 1000", region_enable); end
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 ||
            resp_error !== 1'b0) begin n_fail++;
            $display("FAIL rdat_rst: got rdy=%b v=%b e=%b required 0 0 0",
                     req_ready, resp_valid, resp_error); end
        n_checks++;
        if (region_enable !== 4'b0 || region_address !== 20'h0 ||
            resp_data !== 16'h0) begin n_fail++;
            $display("FAIL rdat_rst_out: got en=%b a=%h d=%h required 0 0 0",
                     region_enable, region_address, resp_data); end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL rdat_ready: got %b required 1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (resp_valid !== 1'b0) begin n_fail++;
                $display("FAIL rdat_dropped: cycle %0d got %b required 0",
                         k, resp_valid); end
            step();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_address    = '0;
        req_write_data = '0;
        test_reset();
        test_ram_read();
        test_video_write_read();
        test_protected();
        test_unmapped();
        test_boundaries();
        test_reset_in_data();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
